// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the MIPS control/datapath and the
// iterative multiply/divide unit. The datapath side is the master.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit. One shift-add or restoring
// divide step per clock on operand magnitudes, followed by a sign fix-up
// cycle that writes HI/LO. Divide by zero short-circuits straight to DONE.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clock,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             r_state;
    logic               r_is_div;
    logic               r_neg_res;   // product / quotient must be negated
    logic               r_neg_rem;   // remainder takes the dividend sign
    logic [WIDTH-1:0]   r_opb;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;       // {upper, multiplier} or {remainder, quotient}
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    // op[0]=0 selects the signed flavour, op[1]=1 selects divide
    logic             w_signed;
    logic             w_is_div;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = ~bus.op[0];
    assign w_is_div = bus.op[1];
    assign w_a_mag  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder and
    // keep the trial subtraction only when it does not go negative.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    // Sign fix-up applied in the FIX cycle
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Control FSM with datapath; all outputs are registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_is_div && (bus.b == '0)) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state   <= RUN;
                            r_busy    <= 1'b1;
                            r_count   <= '0;
                            r_is_div  <= w_is_div;
                            r_neg_res <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            r_neg_rem <= w_signed && bus.a[WIDTH-1];
                            if (w_is_div) begin
                                r_opb <= w_b_mag;
                                r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                            end else begin
                                r_opb <= w_a_mag;
                                r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                            end
                        end
                    end
                end
                RUN: begin
                    r_acc   <= r_is_div ? w_div_next : w_mul_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done     <= 1'b0;
                    r_div_zero <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the multicycle MIPS datapath, for MULT, MULTU, DIV and DIVU.
- Sits directly downstream of the A/B operand registers, taking rs and rt from them.
- Its HI/LO outputs feed the register-bank write-data mux for MFHI/MFLO.
- The control unit starts it with a one-cycle pulse, holds its state machine in a wait state while busy is high, and advances on done.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits. Only 32 is verified.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse from the control unit.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand (A register output).
- b  in  32  rt operand (B register output).
- hi  out  32  HI register: product[63:32] or remainder.
- lo  out  32  LO register: product[31:0] or quotient.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  high together with done when a DIV/DIVU had divisor 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clock; no asynchronous paths.
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, iteration counter=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at edge k: latch op, a and b, then enter RUN with count=0. Changes to a/b after edge k are ignored.
  - Exception: DIV/DIVU with b==0 at edge k goes directly to DONE with div_zero=1. hi/lo are not written (they keep their previous values). done is high in the cycle after edge k.
- RUN:
  - One iteration per edge, 32 iterations on edges k+1..k+32. Enter FIX at edge k+32.
  - Multiply uses shift-add on operand magnitudes (signed ops) or raw values (unsigned ops), giving a 64-bit accumulator.
  - Divide uses restoring division on magnitudes, giving a 32-bit quotient and 32-bit remainder.
- FIX (edge k+33):
  - Apply signs, write hi/lo, enter DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negated if the signs differ, so it truncates toward zero. Remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- DONE:
  - done=1 for exactly one cycle (after edge k+33), then return to IDLE at edge k+34.
  - div_zero is valid only while done=1, and clears on leaving DONE.
- busy:
  - busy=1 in RUN and FIX; busy=0 in IDLE and DONE.
  - Total latency is start sampled to done high: 34 cycles normally, 1 cycle for divide-by-zero.
- hi/lo:
  - Written only at FIX (and by reset).
  - Hold their values otherwise, including while busy, so MFHI/MFLO before completion reads the old value.
- start outside IDLE (RUN, FIX, DONE) is ignored. There is no queueing.
- Reset mid-operation (any state):
  - Next cycle: IDLE, all outputs at reset values.
  - The partial result is discarded; hi/lo are cleared to 0.
- Simultaneous reset and start: reset wins; the operation is not accepted.
- op values are all legal; there is no undefined encoding.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=7 -> done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles 1..33.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULT, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Load hi/lo via MULTU 5*6 (lo=30, hi=0), then DIVU b=0 -> done and div_zero high in the cycle after the start edge; busy never high; hi=0, lo=30 unchanged.
- Start DIVU 100/7 -> re-pulse start at cycle 5 with new operands: ignored, result lo=14, hi=2. Then assert reset at cycle 10 of a new MULT -> next cycle hi=lo=0, busy=done=0; no done pulse follows.
